// File: rtl/data_mem_responder_pkg.sv
// Shared constants, trace record layout and the byte-enable mask helper
// for the data-side memory responder.
package data_mem_responder_pkg;

  localparam logic [31:0] DM_BASE        = 32'h0000_0000;
  localparam int          DM_DEPTH_WORDS = 3072;
  localparam int          TRACE_W        = 96;

  // One committed store as it leaves the trace FIFO (pc in the top bits).
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  // Expand a 4-bit lane enable into a 32-bit bit mask.
  function automatic logic [31:0] byteen_to_mask(input logic [3:0] byteen);
    logic [31:0] mask;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      mask[8*k +: 8] = {8{byteen[k]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// M-stage data bus plus the store-trace drain port.
// master = CPU / bench side, slave = memory responder.
interface data_mem_responder_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        addr_err;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    input  m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, trace_ready,
    output m_data_rdata, trace_valid, trace_pc, trace_addr, trace_data,
           trace_overflow, addr_err
  );
endinterface

// File: rtl/data_mem_responder_trace_fifo.sv
// Generic synchronous FIFO with async reset. Pointers carry one extra wrap
// bit so full and empty are told apart without a counter. A push while full
// is accepted only if a pop frees the head slot on the same edge; otherwise
// it is dropped and the sticky overflow flag is raised.
module trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             overflow
);
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic             overflow_reg, overflow_next;
  logic [WIDTH-1:0] store_reg [DEPTH];
  logic             empty, full, do_pop, do_push;

  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop_valid = ~empty;
  assign do_pop    = pop_valid & pop_ready;
  assign do_push   = push & (~full | do_pop);
  assign pop_data  = empty ? '0 : store_reg[rd_ptr_reg[AW-1:0]];
  assign overflow  = overflow_reg;

  // Next pointer / overflow state from this cycle's push and pop.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (push && full && !do_pop) overflow_next = 1'b1;
  end

  // Control state register; cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  // Record storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) store_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: combinational word read, byte-lane merged stores
// on the clock edge, range checking and a trace FIFO of committed stores.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int TRACE_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [29:0] idx;
  logic        in_range;
  logic        wr_en;
  logic [31:0] mem_word [DEPTH_WORDS];
  logic [31:0] old_word, mask, merged;
  logic        addr_err_reg;
  trace_rec_t  push_rec, head_rec;

  assign idx      = bus.m_data_addr[31:2] - DM_BASE[31:2];
  assign in_range = ({2'b00, idx} < 32'(DEPTH_WORDS));
  assign old_word = in_range ? mem_word[idx[IDX_W-1:0]] : '0;
  assign mask     = byteen_to_mask(bus.m_data_byteen);
  assign merged   = (old_word & ~mask) | (bus.m_data_wdata & mask);
  assign wr_en    = in_range && (bus.m_data_byteen != 4'h0);

  // Reads see pre-edge contents, so a same-cycle store is not forwarded.
  assign bus.m_data_rdata = old_word;

  // One register per word so that reset can clear the whole array at once.
  for (genvar gi = 0; gi < DEPTH_WORDS; gi++) begin : g_word
    logic [31:0] word_reg;

    // Commit the merged word when this word is the store target.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        word_reg <= '0;
      end else if (wr_en && (idx[IDX_W-1:0] == IDX_W'(gi))) begin
        word_reg <= merged;
      end
    end

    assign mem_word[gi] = word_reg;
  end

  // Any address presented beyond the array flags a sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err_reg <= 1'b0;
    end else if (!in_range) begin
      addr_err_reg <= 1'b1;
    end
  end

  assign bus.addr_err = addr_err_reg;

  assign push_rec.pc   = bus.m_inst_addr;
  assign push_rec.addr = {bus.m_data_addr[31:2], 2'b00};
  assign push_rec.data = merged;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (push_rec),
    .pop_valid (bus.trace_valid),
    .pop_ready (bus.trace_ready),
    .pop_data  (head_rec),
    .overflow  (bus.trace_overflow)
  );

  assign bus.trace_pc   = head_rec.pc;
  assign bus.trace_addr = head_rec.addr;
  assign bus.trace_data = head_rec.data;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios followed by random traffic.
// Expected trace records are queued as stores are issued; a negedge monitor
// compares and retires them whenever the DUT presents a head record.
`timescale 1ns/1ps
module tb_data_mem_responder;
  localparam int DEPTH  = 3072;
  localparam int TDEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  data_mem_responder_if bus();

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .TRACE_DEPTH (TDEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_mem [DEPTH];
  rec_t        exp_q[$];
  bit          exp_ovf, exp_err, mon_popped;
  int          pop_count = 0;
  logic [31:0] last_pop_addr, last_pop_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_err = 1'b0;
  endtask

  // Monitor: flags every cycle, head compared and retired on valid & ready.
  always @(negedge clk) begin
    mon_popped = 1'b0;
    if (!reset) begin
      check("trace_valid", {31'b0, bus.trace_valid}, {31'b0, (exp_q.size() > 0)});
      check("trace_overflow", {31'b0, bus.trace_overflow}, {31'b0, exp_ovf});
      check("addr_err", {31'b0, bus.addr_err}, {31'b0, exp_err});
      if (exp_q.size() > 0) begin
        if (bus.trace_valid) begin
          check("head_pc", bus.trace_pc, exp_q[0].pc);
          check("head_addr", bus.trace_addr, exp_q[0].addr);
          check("head_data", bus.trace_data, exp_q[0].data);
        end
        if (bus.trace_ready) begin
          $display("[TB] pop  pc=%08h addr=%08h data=%08h", exp_q[0].pc, exp_q[0].addr, exp_q[0].data);
          last_pop_addr = exp_q[0].addr;
          last_pop_data = exp_q[0].data;
          void'(exp_q.pop_front());
          mon_popped = 1'b1;
          pop_count++;
        end
      end else begin
        check("empty_head_pc", bus.trace_pc, 32'h0);
        check("empty_head_addr", bus.trace_addr, 32'h0);
        check("empty_head_data", bus.trace_data, 32'h0);
      end
    end
  end

  // One bus cycle. Called 1ns after a rising edge; returns 1ns after the next.
  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] pc,
                       input logic rdy, output logic [31:0] rd);
    int unsigned idx;
    bit          inr;
    logic [31:0] word;
    int          pre;
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = wdata;
    bus.m_data_byteen = be;
    bus.m_inst_addr   = pc;
    bus.trace_ready   = rdy;
    #1;
    idx = int'(addr >> 2);
    inr = (addr >> 2) < DEPTH;
    rd  = bus.m_data_rdata;
    check("rdata", rd, inr ? model_mem[idx] : 32'h0);
    if (be != 4'h0)
      $display("[TB] store pc=%08h addr=%08h be=%h wdata=%08h", pc, addr, be, wdata);
    @(negedge clk);
    #1;
    if (!inr) begin
      exp_err = 1'b1;
    end else if (be != 4'h0) begin
      word = model_mem[idx];
      for (int k = 0; k < 4; k++) if (be[k]) word[8*k +: 8] = wdata[8*k +: 8];
      model_mem[idx] = word;
      pre = exp_q.size() + (mon_popped ? 1 : 0);
      if (pre == TDEPTH && !mon_popped) exp_ovf = 1'b1;
      else exp_q.push_back('{pc, {addr[31:2], 2'b00}, word});
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted and released between clock edges.
  task automatic async_reset();
    bus.m_data_byteen = 4'h0;
    bus.m_data_addr   = 32'h0;
    bus.trace_ready   = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check("reset_now_valid", {31'b0, bus.trace_valid}, 32'h0);
    check("reset_now_ovf", {31'b0, bus.trace_overflow}, 32'h0);
    check("reset_now_err", {31'b0, bus.addr_err}, 32'h0);
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d20, addr, wdata;
    logic [3:0]  be;
    int          p0, r;
    bus.m_data_addr   = 32'h0;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'h0;
    bus.m_inst_addr   = 32'h0;
    bus.trace_ready   = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    drive(32'h100, 32'h0, 4'h0, 32'h0, 1'b0, rd);
    check("reset_rdata_0x100", rd, 32'h0);
    check("reset_valid", {31'b0, bus.trace_valid}, 32'h0);

    // Full-word then sub-word store
    drive(32'h10, 32'hDEADBEEF, 4'hF, 32'h3000, 1'b0, rd);
    drive(32'h10, 32'h0, 4'h0, 32'h3004, 1'b0, rd);
    check("full_store_readback", rd, 32'hDEADBEEF);
    check("head_pc_3000", bus.trace_pc, 32'h3000);
    check("head_addr_10", bus.trace_addr, 32'h10);
    check("head_data_deadbeef", bus.trace_data, 32'hDEADBEEF);
    drive(32'h10, 32'h00AA0000, 4'b0100, 32'h3008, 1'b0, rd);
    drive(32'h10, 32'h0, 4'h0, 32'h300C, 1'b1, rd);
    check("subword_merge_read", rd, 32'hDEAABEEF);
    repeat (2) drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, rd);
    check("subword_merge_trace", last_pop_data, 32'hDEAABEEF);

    // Overflow: nine stores with the consumer stalled
    for (int i = 0; i < 9; i++) begin
      wdata = $urandom();
      if (i == 8) d20 = wdata;
      drive(32'(4 * i), wdata, 4'hF, 32'(32'h4000 + 4 * i), 1'b0, rd);
    end
    check("overflow_set", {31'b0, bus.trace_overflow}, 32'h1);
    drive(32'h20, 32'h0, 4'h0, 32'h0, 1'b0, rd);
    check("overflow_mem_written", rd, d20);
    p0 = pop_count;
    repeat (10) drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, rd);
    check("overflow_drain_count", 32'(pop_count - p0), 32'd8);
    check("overflow_drain_last", last_pop_addr, 32'h1C);

    // Simultaneous push and pop on a full FIFO
    async_reset();
    for (int i = 0; i < 8; i++)
      drive(32'(32'h40 + 4 * i), $urandom(), 4'hF, 32'(32'h5000 + 4 * i), 1'b0, rd);
    drive(32'h80, 32'h12345678, 4'hF, 32'h5020, 1'b1, rd);
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b0, rd);
    check("full_pushpop_no_ovf", {31'b0, bus.trace_overflow}, 32'h0);
    p0 = pop_count;
    repeat (10) drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, rd);
    check("full_pushpop_occupancy", 32'(pop_count - p0), 32'd8);
    check("full_pushpop_last", last_pop_addr, 32'h80);

    // Simultaneous push and pop on an empty FIFO
    drive(32'h90, 32'hCAFEF00D, 4'hF, 32'h5100, 1'b1, rd);
    check("empty_pushpop_valid", {31'b0, bus.trace_valid}, 32'h1);
    check("empty_pushpop_addr", bus.trace_addr, 32'h90);
    drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, rd);

    // Range boundary and out-of-range store
    drive(32'h2FFC, 32'hA5A5A5A5, 4'hF, 32'h6000, 1'b1, rd);
    drive(32'h2FFC, 32'h0, 4'h0, 32'h6004, 1'b1, rd);
    check("last_word_readback", rd, 32'hA5A5A5A5);
    check("last_word_no_err", {31'b0, bus.addr_err}, 32'h0);
    drive(32'h3000, 32'hFFFFFFFF, 4'hF, 32'h6008, 1'b1, rd);
    check("oob_err_set", {31'b0, bus.addr_err}, 32'h1);
    check("oob_no_trace", {31'b0, bus.trace_valid}, 32'h0);
    drive(32'h3000, 32'h0, 4'h0, 32'h600C, 1'b1, rd);
    check("oob_read_zero", rd, 32'h0);

    // Random traffic against the reference model
    async_reset();
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 5)       addr = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
      else if (r < 12) addr = 32'h2FF0 + 32'($urandom_range(0, 3)) * 4;
      else             addr = 32'($urandom_range(0, 31)) * 4;
      addr[1:0] = 2'($urandom_range(0, 3));
      be    = 4'($urandom_range(0, 15));
      wdata = $urandom();
      drive(addr, wdata, be, 32'(32'h8000 + 4 * i), 1'($urandom_range(0, 1)), rd);
    end
    repeat (10) drive(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, rd);

    // Reset mid-operation with three records queued
    async_reset();
    drive(32'h10, 32'h11111111, 4'hF, 32'h9000, 1'b0, rd);
    drive(32'h14, 32'h22222222, 4'hF, 32'h9004, 1'b0, rd);
    drive(32'h18, 32'h33333333, 4'hF, 32'h9008, 1'b0, rd);
    check("three_queued_valid", {31'b0, bus.trace_valid}, 32'h1);
    async_reset();
    drive(32'h10, 32'h0, 4'h0, 32'h0, 1'b0, rd);
    check("after_reset_read_0x10", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-side memory responder for the pipelined MIPS core: the slave end of the `m_data_*` interface that the CPU top drives from its M stage. It returns read data combinationally and commits byte-enabled stores on the clock edge. Every committed store is logged into a small trace FIFO so the bench and grader can drain `@pc: *addr <= data` records with backpressure. It sits beside the CPU top in the SoC/testbench wrapper and replaces the behavioural DM model.

## Interface

Parameters:

- `DEPTH_WORDS`, default 3072: number of 32-bit words, giving byte range 0x0000–0x2FFF.
- `TRACE_DEPTH`, default 8: trace FIFO entries; must be a power of two, at least 2.

Ports:

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `m_data_addr` in 32: byte address from the M stage.
- `m_data_wdata` in 32: lane-aligned store data.
- `m_data_byteen` in 4: per-lane write enable; 0 means no store.
- `m_inst_addr` in 32: PC of the M-stage instruction.
- `m_data_rdata` out 32: word at `m_data_addr[..:2]`.
- `trace_valid` out 1: FIFO head is valid.
- `trace_ready` in 1: consumer accepts the head this cycle.
- `trace_pc` out 32: head record PC.
- `trace_addr` out 32: head record word address, with low 2 bits forced to 0.
- `trace_data` out 32: head record full word after the merge.
- `trace_overflow` out 1: sticky; a record was dropped.
- `addr_err` out 1: sticky; an access fell outside the range.

## Operation

- **Word index:** `idx = m_data_addr[31:2]`. The address is in range iff `idx < DEPTH_WORDS`.
- **Read:** purely combinational. `m_data_rdata = mem[idx]` when in range, 0 otherwise.
  - Read-during-write returns the pre-edge contents.
  - Sub-word extraction is not done here; the CPU's data-extend logic owns it.
- **Write:** occurs when `m_data_byteen != 0` and the address is in range. On the rising edge, each lane `k` with `byteen[k]=1` takes `wdata[8k+7:8k]`; other lanes are kept.
- **Merged word:** `merged = (old & ~mask) | (wdata & mask)`, where `mask` is `byteen` expanded to 32 bits.
- **Trace push:** every in-range write pushes `{m_inst_addr, {idx,2'b00}, merged}`.
- **Out-of-range access:** any access with byteen≠0 or a nonzero address beyond range sets `addr_err` on the edge. An out-of-range write is ignored and not traced.
- **FIFO:** pointers are `log2(TRACE_DEPTH)+1` bits wide and wrap modulo 2·`TRACE_DEPTH`.
  - Full when the pointers differ only in the MSB; empty when they are equal.
  - A pop happens when `trace_valid & trace_ready`.
- **Push and pop in the same cycle:**
  - Empty FIFO: the push is stored and the pop is not performed (`trace_valid` is 0).
  - Full FIFO: both are performed; occupancy is unchanged and there is no overflow.
- **Push while full without a pop:** the record is dropped, memory is still written, and `trace_overflow` is set.
- **Reset (asynchronous, at any time):** clears all memory words to 0, both FIFO pointers, `trace_overflow` and `addr_err`.
  - An in-flight store on the reset edge is lost.
  - Sticky flags clear only on reset.

## Timing

Reset values:

- `m_data_rdata` is 0.
- `trace_valid` is 0.
- `trace_pc`, `trace_addr` and `trace_data` are don't-care, driven as 0 when empty.
- `trace_overflow` and `addr_err` are 0.

Latency:

- Read: 0 cycles.
- Store: visible on `m_data_rdata` starting the cycle after the edge.
- Trace: a record pushed at edge N gives `trace_valid=1` after edge N when the FIFO was empty.
- Pop: takes effect at the edge where `valid & ready`; the next head appears after that edge.

Ordering and handshake:

- Records leave in store order.
- `trace_valid` does not depend combinationally on `trace_ready`.
- Head outputs are stable while `valid & ~ready`.

## Structure

- Shared package/constants file:
  - `DM_BASE`
  - `DM_DEPTH_WORDS`
  - the trace record width (96)
  - a function expanding byteen to a 32-bit mask
- One sub-module, `trace_fifo`: a generic synchronous FIFO with async reset, parameterized width and depth, valid/ready out and a push/full in.
- The top holds the memory array, the lane merge and the range check.

## Test plan

1. **Reset, then read address 0x100:** `m_data_rdata`=0, `trace_valid`=0, flags 0.
2. **Full-word then sub-word stores:**
   - Store `wdata`=0xDEADBEEF, byteen=4'hF, addr 0x10, pc 0x3000. Next cycle `rdata`=0xDEADBEEF. Trace head is {0x3000, 0x10, 0xDEADBEEF}.
   - Then a store with byteen=4'b0100, wdata=0x00AA0000 gives a merged word of 0xDEAABEEF.
3. **Overflow:**
   - Hold `trace_ready`=0 and issue 9 stores (addr 0,4,…,0x20). Expect 8 entries and `trace_overflow`=1.
   - Memory at 0x20 is still written.
   - Draining 8 pops returns addr 0…0x1C in order.
4. **Simultaneous push and pop:**
   - With the FIFO full and `trace_ready`=1, one store: occupancy stays 8 and `trace_overflow` stays 0.
   - With the FIFO empty and `trace_ready`=1, one store: the record is retained and valid the next cycle.
5. **Out of range:** store to 0x3000 with byteen=4'hF. Result: `addr_err`=1, no trace record, and a read of 0x3000 returns 0.
6. **Reset mid-operation:** assert `reset` asynchronously between edges while 3 records are queued. Immediately `trace_valid`=0. After release, a read of the previously written 0x10 returns 0.
